axi_4_slave_write_ctrl: RTL and testbench

AXI-4 slave-side write channel controller. It accepts one write burst at a time on the AW and W channels and turns each W beat into a strobed write on a simple memory port. It returns the B response when the burst completes. It sits directly downstream of the AXI-4 master write path and consumes the shared write-address, write-data and write-response channel structs.

---
 rtl/axi_4_slave_write_ctrl_pkg.sv | 66 ++++++
 rtl/axi_4_slave_write_ctrl_addr_gen.sv | 35 +++
 rtl/axi_4_slave_write_ctrl.sv | 118 +++++++++++
 tb/tb_axi_4_slave_write_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_4_slave_write_ctrl_pkg.sv
// Shared AXI-4 slave definitions: bus widths, burst/response encodings,
// slave FSM states, channel structs and the AW legality check.
package axi_4_slave_write_ctrl_pkg;

  localparam int XLEN           = 32;
  localparam int DATA_BUS_WIDTH = 512;
  localparam int ADDR_W         = XLEN;
  localparam int DATA_W         = DATA_BUS_WIDTH;
  localparam int STRB_W         = DATA_W / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    SLAVE_IDLE  = 2'd0,
    DATA_STORE  = 2'd1,
    WAIT_BREADY = 2'd2
  } axi_4_slave_states_e;

  typedef struct packed {
    logic [XLEN-1:0]   awid;
    logic [ADDR_W-1:0] axaddr;
    logic [7:0]        axlen;
    logic [2:0]        axsize;
    logic [1:0]        axburst;
    logic              axlock;
    logic [3:0]        axcache;
    logic [2:0]        axprot;
    logic [3:0]        axqos;
  } read_write_address_channel_t;

  typedef struct packed {
    logic [XLEN-1:0]   wid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
  } write_data_channel_t;

  typedef struct packed {
    logic [XLEN-1:0] bid;
    logic [1:0]      bresp;
  } write_response_channel_t;

  // Burst parameters this slave cannot honour; such bursts are drained and
  // answered with SLVERR.
  function automatic logic aw_params_illegal(
    input logic [ADDR_W-1:0] addr,
    input logic [7:0]        len,
    input logic [2:0]        size,
    input logic [1:0]        burst
  );
    logic [ADDR_W-1:0] mask;
    logic              wrap_len_ok;
    mask        = (ADDR_W'(1) << size) - ADDR_W'(1);
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    aw_params_illegal = (size > 3'd6) ||
                        (burst == 2'b11) ||
                        ((burst == BURST_WRAP) && !wrap_len_ok) ||
                        ((burst == BURST_WRAP) && ((addr & mask) != '0));
  endfunction

endpackage

// File: rtl/axi_4_slave_write_ctrl_addr_gen.sv
// Combinational AXI-4 burst next-address generator (FIXED/INCR/WRAP).
// Arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W.
module axi_4_burst_addr_gen
  import axi_4_slave_write_ctrl_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] bound;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_addr;

  assign step  = ADDR_W'(1) << size;
  assign bound = (ADDR_W'(len) + ADDR_W'(1)) << size;

  // INCR realigns after an unaligned first beat; WRAP stays inside its window.
  assign incr_addr = (addr & ~(step - ADDR_W'(1))) + step;
  assign wrap_addr = (addr & ~(bound - ADDR_W'(1))) |
                     ((addr + step) & (bound - ADDR_W'(1)));

  always_comb begin
    next_addr = addr;
    case (burst)
      BURST_INCR: next_addr = incr_addr;
      BURST_WRAP: next_addr = wrap_addr;
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_4_slave_write_ctrl.sv
// AXI-4 slave write controller: one burst at a time, each W beat becomes a
// strobed memory write, B response returned once the burst completes.
module axi_4_slave_write_ctrl
  import axi_4_slave_write_ctrl_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        awvalid,
  output logic                        awready,
  input  read_write_address_channel_t aw_ch,
  input  logic                        wvalid,
  output logic                        wready,
  input  write_data_channel_t         w_ch,
  output logic                        bvalid,
  input  logic                        bready,
  output write_response_channel_t     b_ch,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [STRB_W-1:0]           mem_wstrb,
  input  logic                        mem_ready,
  output logic [1:0]                  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // this block never lets its own valid depend on the partner's ready.
  axi_4_slave_states_e state;
  logic [ADDR_W-1:0]   cur_addr;
  logic [XLEN-1:0]     lat_id;
  logic [7:0]          lat_len;
  logic [2:0]          lat_size;
  logic [1:0]          lat_burst;
  logic [7:0]          beat_cnt;
  logic                err;

  logic                in_store;
  logic                beat_fire;
  logic                last_beat;
  logic [ADDR_W-1:0]   next_addr;
  logic                unused_aw;

  assign unused_aw = &{1'b0, aw_ch.axlock, aw_ch.axcache, aw_ch.axprot, aw_ch.axqos};

  axi_4_burst_addr_gen u_addr_gen (
    .addr      (cur_addr),
    .size      (lat_size),
    .len       (lat_len),
    .burst     (lat_burst),
    .next_addr (next_addr)
  );

  // Outputs are gated by rst_n so they read 0 for the whole reset window.
  assign in_store  = rst_n && (state == DATA_STORE);
  assign awready   = rst_n && (state == SLAVE_IDLE);
  assign bvalid    = rst_n && (state == WAIT_BREADY);
  assign wready    = in_store && (err || mem_ready);
  assign beat_fire = in_store && wvalid && wready;
  assign last_beat = (beat_cnt == lat_len);

  assign mem_we    = in_store && wvalid && !err;
  assign mem_addr  = cur_addr;
  assign mem_wdata = in_store ? w_ch.wdata : '0;
  assign mem_wstrb = in_store ? w_ch.wstrb : '0;

  assign b_ch.bid   = lat_id;
  assign b_ch.bresp = err ? RESP_SLVERR : RESP_OKAY;
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SLAVE_IDLE;
      cur_addr  <= '0;
      lat_id    <= '0;
      lat_len   <= '0;
      lat_size  <= '0;
      lat_burst <= '0;
      beat_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        SLAVE_IDLE: begin
          if (awvalid) begin
            cur_addr  <= aw_ch.axaddr;
            lat_id    <= aw_ch.awid;
            lat_len   <= aw_ch.axlen;
            lat_size  <= aw_ch.axsize;
            lat_burst <= aw_ch.axburst;
            beat_cnt  <= '0;
            err       <= aw_params_illegal(aw_ch.axaddr, aw_ch.axlen,
                                           aw_ch.axsize, aw_ch.axburst);
            state     <= DATA_STORE;
          end
        end
        DATA_STORE: begin
          if (beat_fire) begin
            beat_cnt <= beat_cnt + 8'd1;
            cur_addr <= next_addr;
            // axlen alone sets the burst length; a mismatched wlast or wid
            // only poisons the response.
            if ((w_ch.wlast != last_beat) || (w_ch.wid != lat_id)) begin
              err <= 1'b1;
            end
            if (last_beat) begin
              state <= WAIT_BREADY;
            end
          end
        end
        WAIT_BREADY: begin
          if (bready) begin
            state <= SLAVE_IDLE;
          end
        end
        default: state <= SLAVE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_4_slave_write_ctrl.sv
// Bench for axi_4_slave_write_ctrl: directed vector table, reset/back-pressure
// sequences and randomized bursts checked against a behavioural burst model.
module tb_axi_4_slave_write_ctrl;
  import axi_4_slave_write_ctrl_pkg::*;

  localparam int REC_W = ADDR_W + DATA_W + STRB_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                        awvalid, awready, wvalid, wready, bvalid, bready;
  logic                        mem_we, mem_ready;
  read_write_address_channel_t aw_ch;
  write_data_channel_t         w_ch;
  write_response_channel_t     b_ch;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [STRB_W-1:0]           mem_wstrb;
  logic [1:0]                  dbg_state;

  axi_4_slave_write_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .awvalid   (awvalid),
    .awready   (awready),
    .aw_ch     (aw_ch),
    .wvalid    (wvalid),
    .wready    (wready),
    .w_ch      (w_ch),
    .bvalid    (bvalid),
    .bready    (bready),
    .b_ch      (b_ch),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  logic [REC_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [REC_W-1:0] got, input logic [REC_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference model: burst legality and address sequence from the protocol rules.
  function automatic bit model_aw_err(logic [31:0] a, logic [7:0] len, logic [2:0] size, logic [1:0] burst);
    if (size > 3'd6) return 1'b1;
    if (burst == 2'b11) return 1'b1;
    if (burst == 2'b10) begin
      if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15})) return 1'b1;
      if ((a % (32'd1 << size)) != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_next(logic [31:0] a, logic [2:0] size, logic [7:0] len, logic [1:0] burst);
    longint unsigned sb, bound, base, au;
    au = a;
    sb = 64'd1 << size;
    case (burst)
      2'b01: return 32'((au / sb) * sb + sb);
      2'b10: begin
        bound = (longint'(len) + 1) * sb;
        base  = au - (au % bound);
        return 32'(base + ((au - base + sb) % bound));
      end
      default: return a;
    endcase
  endfunction

  // Scoreboard: every committed memory write must match the head of exp_q.
  task automatic sample_write(inout int n_wr, inout logic [3:0][31:0] got_a);
    logic [REC_W-1:0] e;
    if (mem_we && mem_ready) begin
      if (n_wr < 4) got_a[n_wr] = mem_addr;
      n_wr++;
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", mem_addr, 64'hdead_0000);
      end else begin
        e = exp_q.pop_front();
        check_wide("mem_write_record", {mem_addr, mem_wdata, mem_wstrb}, e);
      end
    end
  endtask

  // Driver: one complete burst. Called and returning in the low clock phase.
  task automatic run_burst(input logic [31:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int last_at,
                           input bit bad_wid, input int rdy_mode, input int hold_b, input int abort_after,
                           output int n_wr, output logic [3:0][31:0] got_a, output logic [1:0] got_resp);
    logic [31:0]       m_addr;
    bit                m_err;
    int                b, cyc, prepared, eff_last;
    logic [DATA_W-1:0] d;
    logic [STRB_W-1:0] s;
    logic [1:0]        exp_resp;
    n_wr     = 0;
    got_a    = '0;
    got_resp = '0;
    d        = '0;
    s        = '0;
    eff_last = (last_at < 0) ? int'(len) : last_at;
    m_addr   = addr;
    m_err    = model_aw_err(addr, len, size, burst);

    aw_ch         = '0;
    aw_ch.awid    = id;
    aw_ch.axaddr  = addr;
    aw_ch.axlen   = len;
    aw_ch.axsize  = size;
    aw_ch.axburst = burst;
    aw_ch.axcache = 4'($urandom());
    awvalid       = 1'b1;
    wvalid        = 1'b1;
    w_ch          = '{wid: id, wdata: '1, wstrb: '1, wlast: 1'b1};
    mem_ready     = 1'b1;
    #1;
    check("awready_idle", awready, 1);
    check("wready_in_idle", wready, 0);
    check("mem_we_in_idle", mem_we, 0);
    @(negedge clk);
    awvalid = 1'b0;

    b = 0; cyc = 0; prepared = -1;
    while (b <= int'(len) && cyc < 200 && !(abort_after >= 0 && b > abort_after)) begin
      if (prepared != b) begin
        for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = $urandom();
        s = {$urandom(), $urandom()};
        if (!m_err) exp_q.push_back({m_addr, d, s});
        prepared = b;
      end
      wvalid     = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      mem_ready  = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      w_ch.wid   = (bad_wid && b == 0) ? ~id : id;
      w_ch.wlast = (b == eff_last);
      w_ch.wdata = d;
      w_ch.wstrb = s;
      #1;
      check("wready", wready, m_err ? 1'b1 : mem_ready);
      check("mem_we", mem_we, wvalid && !m_err);
      check("bvalid_during_w", bvalid, 0);
      check("awready_during_w", awready, 0);
      sample_write(n_wr, got_a);
      if (wvalid && wready) begin
        if (((b == eff_last) != (b == int'(len))) || (bad_wid && b == 0)) m_err = 1'b1;
        m_addr = model_next(m_addr, size, len, burst);
        b++;
      end
      cyc++;
      @(negedge clk);
    end
    wvalid = 1'b0;

    if (abort_after >= 0) begin
      rst_n  = 1'b0;
      wvalid = 1'b1;
      #1;
      check("rst_awready", awready, 0);
      check("rst_wready", wready, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_bvalid", bvalid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_awready", awready, 1);
      check("post_rst_wready", wready, 0);
      check("post_rst_mem_we", mem_we, 0);
      check("post_rst_bvalid", bvalid, 0);
      check("post_rst_b_ch", b_ch, 0);
      check("post_rst_mem_addr", mem_addr, 0);
      check("post_rst_mem_wdata_lo", mem_wdata[63:0], 0);
      check("post_rst_mem_wstrb", mem_wstrb, 0);
      wvalid = 1'b0;
      exp_q.delete();
      return;
    end

    check("w_beats_accepted", b, int'(len) + 1);
    check("exp_q_drained", exp_q.size(), 0);
    exp_q.delete();
    exp_resp = m_err ? 2'b10 : 2'b00;
    #1;
    check("bvalid_latency", bvalid, 1);
    check("bid", b_ch.bid, id);
    check("bresp", b_ch.bresp, exp_resp);
    for (int h = 0; h < hold_b; h++) begin
      @(negedge clk);
      #1;
      check("bvalid_hold", bvalid, 1);
      check("bid_hold", b_ch.bid, id);
      check("bresp_hold", b_ch.bresp, exp_resp);
      check("awready_hold", awready, 0);
    end
    got_resp = b_ch.bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    #1;
    check("awready_after_b", awready, 1);
    check("bvalid_after_b", bvalid, 0);
  endtask

  typedef struct {
    logic [1:0]        burst;
    logic [31:0]       addr;
    logic [7:0]        len;
    logic [2:0]        size;
    int                last_at;
    bit                bad_wid;
    int                rdy_mode;
    int                hold_b;
    int                exp_writes;
    logic [1:0]        exp_resp;
    logic [3:0][31:0]  exp_a;
  } vec_t;

  vec_t vecs[11];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int               n_wr;
    logic [3:0][31:0] got_a;
    logic [1:0]       got_resp, burst;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;

    vecs[0]  = '{2'b01, 32'h1000, 8'd3, 3'd6, -1, 1'b0, 0, 5, 4, 2'b00, {32'h10C0, 32'h1080, 32'h1040, 32'h1000}};
    vecs[1]  = '{2'b10, 32'h1030, 8'd3, 3'd4, -1, 1'b0, 0, 0, 4, 2'b00, {32'h1020, 32'h1010, 32'h1000, 32'h1030}};
    vecs[2]  = '{2'b00, 32'h0500, 8'd2, 3'd5, -1, 1'b0, 1, 0, 3, 2'b00, {32'h0, 32'h500, 32'h500, 32'h500}};
    vecs[3]  = '{2'b01, 32'h1003, 8'd2, 3'd2, -1, 1'b0, 0, 0, 3, 2'b00, {32'h0, 32'h1008, 32'h1004, 32'h1003}};
    vecs[4]  = '{2'b01, 32'h2000, 8'd3, 3'd2,  1, 1'b0, 0, 0, 2, 2'b10, {32'h0, 32'h0, 32'h2004, 32'h2000}};
    vecs[5]  = '{2'b11, 32'h3000, 8'd1, 3'd2, -1, 1'b0, 0, 0, 0, 2'b10, '0};
    vecs[6]  = '{2'b10, 32'h0100, 8'd2, 3'd2, -1, 1'b0, 0, 0, 0, 2'b10, '0};
    vecs[7]  = '{2'b10, 32'h0102, 8'd3, 3'd2, -1, 1'b0, 0, 0, 0, 2'b10, '0};
    vecs[8]  = '{2'b01, 32'h0000, 8'd0, 3'd7, -1, 1'b0, 0, 0, 0, 2'b10, '0};
    vecs[9]  = '{2'b01, 32'h0040, 8'd1, 3'd3, -1, 1'b1, 0, 0, 1, 2'b10, {32'h0, 32'h0, 32'h0, 32'h40}};
    vecs[10] = '{2'b01, 32'hFFFF_FFC0, 8'd1, 3'd6, -1, 1'b0, 0, 0, 2, 2'b00, {32'h0, 32'h0, 32'h0, 32'hFFFF_FFC0}};

    rst_n = 1'b0; awvalid = 1'b0; wvalid = 1'b1; bready = 1'b0; mem_ready = 1'b1;
    aw_ch = '0;
    w_ch  = '{wid: 32'h5, wdata: '1, wstrb: '1, wlast: 1'b1};
    repeat (3) @(negedge clk);
    #1;
    check("reset_awready", awready, 0);
    check("reset_wready", wready, 0);
    check("reset_bvalid", bvalid, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_b_ch", b_ch, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_mem_wdata_lo", mem_wdata[63:0], 0);
    check("reset_mem_wstrb", mem_wstrb, 0);
    check("reset_state", dbg_state, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    wvalid = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_burst(32'h100 + i, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, vecs[i].last_at,
                vecs[i].bad_wid, vecs[i].rdy_mode, vecs[i].hold_b, -1, n_wr, got_a, got_resp);
      check("vec_write_count", n_wr, vecs[i].exp_writes);
      check("vec_bresp", got_resp, vecs[i].exp_resp);
      for (int k = 0; k < vecs[i].exp_writes && k < 4; k++) check("vec_addr", got_a[k], vecs[i].exp_a[k]);
    end

    run_burst(32'h77, 32'h4000, 8'd7, 3'd3, 2'b01, -1, 1'b0, 0, 0, 1, n_wr, got_a, got_resp);
    check("abort_writes", n_wr, 2);
    run_burst(32'h78, 32'h5000, 8'd1, 3'd3, 2'b01, -1, 1'b0, 0, 0, -1, n_wr, got_a, got_resp);
    check("after_abort_resp", got_resp, 2'b00);
    check("after_abort_addr1", got_a[1], 32'h5008);

    for (int r = 0; r < 40; r++) begin
      burst = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      size  = ($urandom_range(0, 19) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      addr  = $urandom();
      if (burst == 2'b10) begin
        case ($urandom_range(0, 3))
          0: len = 8'd1;
          1: len = 8'd3;
          2: len = 8'd7;
          default: len = 8'd15;
        endcase
        if ($urandom_range(0, 9) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      end else begin
        len = 8'($urandom_range(0, 7));
      end
      run_burst($urandom(), addr, len, size, burst,
                ($urandom_range(0, 9) == 0) ? $urandom_range(0, 8) : -1,
                ($urandom_range(0, 9) == 0), 2, $urandom_range(0, 3), -1, n_wr, got_a, got_resp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
